// File: rtl/conv_window_sequencer.sv
// Convolution loop sequencer: walks every valid output window and kernel tap of one layer pass,
// presenting indices over valid/ready. Optional SEQ_STALL_CNT_EN adds a saturating stall counter.
module conv_window_sequencer #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K_SIZE = 3,
  localparam int RW = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = ($clog2(IMG_W) > 1) ? $clog2(IMG_W) : 1,
  localparam int KW = ($clog2(K_SIZE) > 1) ? $clog2(K_SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic [KW-1:0] k_row,
  output logic [KW-1:0] k_col,
`ifdef SEQ_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic          win_last,
  output logic          pass_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - K_SIZE);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - K_SIZE);
  localparam logic [KW-1:0] K_MAX   = KW'(K_SIZE - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [KW-1:0] kr_q, kr_d;
  logic [KW-1:0] kc_q, kc_d;
  logic          fire_s;
  logic          win_last_s;
  logic          pass_last_s;

  assign fire_s      = idx_valid && idx_ready;
  assign win_last_s  = (kc_q == K_MAX) && (kr_q == K_MAX);
  assign pass_last_s = win_last_s && (col_q == COL_MAX) && (row_q == ROW_MAX);

  // Next-state and index advance; k_col is innermost, out_row outermost.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!fire_s) begin
          state_d = S_RUN;
        end else if (pass_last_s) begin
          state_d = S_DONE;
          row_d   = '0;
          col_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
        end else if (kc_q != K_MAX) begin
          kc_d = kc_q + KW'(1);
        end else if (kr_q != K_MAX) begin
          kc_d = '0;
          kr_d = kr_q + KW'(1);
        end else if (col_q != COL_MAX) begin
          kc_d  = '0;
          kr_d  = '0;
          col_d = col_q + CW'(1);
        end else begin
          kc_d  = '0;
          kr_d  = '0;
          col_d = '0;
          row_d = row_q + RW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign idx_valid = (state_q == S_RUN);
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign k_row     = kr_q;
  assign k_col     = kc_q;
  assign win_last  = idx_valid && win_last_s;
  assign pass_last = idx_valid && pass_last_s;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter: cleared on accepted start, saturating, held after the pass.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = 16'h0000;
    end else if ((state_q == S_RUN) && !idx_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed self-checking bench for conv_window_sequencer: three parameter sets
// (5x5 k3, 4-wide 3-high k1, 3x3 k3), stalls, held start and mid-pass reset.
module tb_conv_window_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idx_ready = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sel = 0;

  always #5 clk = ~clk;

  logic busy_a, done_a, valid_a, wl_a, pl_a;
  logic [2:0] row_a, col_a;
  logic [1:0] kr_a, kc_a;
  logic busy_b, done_b, valid_b, wl_b, pl_b;
  logic [1:0] row_b, col_b;
  logic [0:0] kr_b, kc_b;
  logic busy_c, done_c, valid_c, wl_c, pl_c;
  logic [1:0] row_c, col_c;
  logic [1:0] kr_c, kc_c;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_a, stall_b, stall_c;
`endif

  conv_window_sequencer #(.IMG_W(5), .IMG_H(5), .K_SIZE(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .idx_valid(valid_a), .idx_ready(idx_ready), .out_row(row_a), .out_col(col_a),
    .k_row(kr_a), .k_col(kc_a),
`ifdef SEQ_STALL_CNT_EN
    .stall_cnt(stall_a),
`endif
    .win_last(wl_a), .pass_last(pl_a));

  conv_window_sequencer #(.IMG_W(4), .IMG_H(3), .K_SIZE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .idx_valid(valid_b), .idx_ready(idx_ready), .out_row(row_b), .out_col(col_b),
    .k_row(kr_b), .k_col(kc_b),
`ifdef SEQ_STALL_CNT_EN
    .stall_cnt(stall_b),
`endif
    .win_last(wl_b), .pass_last(pl_b));

  conv_window_sequencer #(.IMG_W(3), .IMG_H(3), .K_SIZE(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .idx_valid(valid_c), .idx_ready(idx_ready), .out_row(row_c), .out_col(col_c),
    .k_row(kr_c), .k_col(kc_c),
`ifdef SEQ_STALL_CNT_EN
    .stall_cnt(stall_c),
`endif
    .win_last(wl_c), .pass_last(pl_c));

  logic o_busy, o_done, o_valid, o_wl, o_pl;
  logic [31:0] o_row, o_col, o_kr, o_kc, o_stall;

  always_comb begin
    o_stall = 32'd0;
    case (sel)
      1: begin
        o_busy = busy_b; o_done = done_b; o_valid = valid_b; o_wl = wl_b; o_pl = pl_b;
        o_row = 32'(row_b); o_col = 32'(col_b); o_kr = 32'(kr_b); o_kc = 32'(kc_b);
`ifdef SEQ_STALL_CNT_EN
        o_stall = 32'(stall_b);
`endif
      end
      2: begin
        o_busy = busy_c; o_done = done_c; o_valid = valid_c; o_wl = wl_c; o_pl = pl_c;
        o_row = 32'(row_c); o_col = 32'(col_c); o_kr = 32'(kr_c); o_kc = 32'(kc_c);
`ifdef SEQ_STALL_CNT_EN
        o_stall = 32'(stall_c);
`endif
      end
      default: begin
        o_busy = busy_a; o_done = done_a; o_valid = valid_a; o_wl = wl_a; o_pl = pl_a;
        o_row = 32'(row_a); o_col = 32'(col_a); o_kr = 32'(kr_a); o_kc = 32'(kc_a);
`ifdef SEQ_STALL_CNT_EN
        o_stall = 32'(stall_a);
`endif
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    start_a = (sel == 0) ? v : 1'b0;
    start_b = (sel == 1) ? v : 1'b0;
    start_c = (sel == 2) ? v : 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(o_busy), 32'd0);
    check({tag, ".done"}, 32'(o_done), 32'd0);
    check({tag, ".valid"}, 32'(o_valid), 32'd0);
    check({tag, ".row"}, o_row, 32'd0);
    check({tag, ".col"}, o_col, 32'd0);
    check({tag, ".kr"}, o_kr, 32'd0);
    check({tag, ".kc"}, o_kc, 32'd0);
    check({tag, ".wl"}, 32'(o_wl), 32'd0);
    check({tag, ".pl"}, 32'(o_pl), 32'd0);
  endtask

  // Expected indices of beat b derived arithmetically from the loop nest.
  task automatic check_beat(input string tag, input int b, input int k, input int w, input int h);
    int ow = w - k + 1;
    int total = (h - k + 1) * ow * k * k;
    check({tag, ".valid"}, 32'(o_valid), 32'd1);
    check({tag, ".busy"}, 32'(o_busy), 32'd1);
    check({tag, ".done"}, 32'(o_done), 32'd0);
    check({tag, ".kc"}, o_kc, 32'(b % k));
    check({tag, ".kr"}, o_kr, 32'((b / k) % k));
    check({tag, ".col"}, o_col, 32'((b / (k * k)) % ow));
    check({tag, ".row"}, o_row, 32'(b / (k * k * ow)));
    check({tag, ".wl"}, 32'(o_wl), 32'((b % (k * k)) == (k * k - 1)));
    check({tag, ".pl"}, 32'(o_pl), 32'(b == total - 1));
  endtask

  // Called at posedge+1 in IDLE; issues start and runs a full pass to IDLE.
  task automatic run_pass(input string tag, input int k, input int w, input int h,
                          input bit stall, input bit hold_start);
    int total = (h - k + 1) * (w - k + 1) * k * k;
    int b = 0;
    int cyc = 0;
    int stalls = 0;
    set_start(1'b1);
    idx_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) set_start(1'b0);
    while (b < total && cyc < 2000) begin
      check_beat(tag, b, k, w, h);
      idx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!idx_ready) stalls++;
      @(posedge clk); #1;
      if (idx_ready) b++;
      cyc++;
    end
    idx_ready = 1'b1;
    check({tag, ".beats"}, 32'(b), 32'(total));
    if (!stall) check({tag, ".cycles"}, 32'(cyc), 32'(total));
    check({tag, ".done_pulse"}, 32'(o_done), 32'd1);
    check({tag, ".done_busy"}, 32'(o_busy), 32'd1);
    check({tag, ".done_valid"}, 32'(o_valid), 32'd0);
    check({tag, ".done_pl"}, 32'(o_pl), 32'd0);
`ifdef SEQ_STALL_CNT_EN
    check({tag, ".stall_cnt"}, o_stall, 32'(stalls));
`endif
    @(posedge clk); #1;
    check({tag, ".after_busy"}, 32'(o_busy), 32'd0);
    check({tag, ".after_done"}, 32'(o_done), 32'd0);
`ifdef SEQ_STALL_CNT_EN
    check({tag, ".stall_hold"}, o_stall, 32'(stalls));
`endif
  endtask

  initial begin
    #3;
    sel = 0; #0 check_idle("rst_a");
    sel = 1; #0 check_idle("rst_b");
    sel = 2; #0 check_idle("rst_c");
    sel = 0;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("idle_a");

    run_pass("full_a", 3, 5, 5, 1'b0, 1'b0);
    run_pass("stall_a", 3, 5, 5, 1'b1, 1'b0);

    // start held high: one pass only, then restart exactly one IDLE cycle later
    run_pass("hold_a", 3, 5, 5, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check_beat("hold_restart", 0, 3, 5, 5);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check_beat("mid_a", i + 1, 3, 5, 5);
    end
    rst_n = 1'b0;
    #1 check_idle("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({"rst_nodone"}, 32'(o_done), 32'd0);
      check({"rst_nobusy"}, 32'(o_busy), 32'd0);
    end
    run_pass("restart_a", 3, 5, 5, 1'b0, 1'b0);

    sel = 1;
    #0 check_idle("idle_b");
    run_pass("k1_b", 1, 4, 3, 1'b0, 1'b0);

    sel = 2;
    #0 check_idle("idle_c");
    run_pass("single_c", 3, 3, 3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Loop controller for one CNN convolution layer. It walks every valid (non-padded, stride-1) output position of an IMG_H×IMG_W feature map and, for each position, every K_SIZE×K_SIZE kernel tap. It presents the resulting indices to the MAC/address datapath over a valid/ready handshake. It replaces the free-running wrap counters previously chained by hand, and adds start/done sequencing and backpressure.

## Interface
- IMG_W, 5, input feature-map width (≥ K_SIZE)
- IMG_H, 5, input feature-map height (≥ K_SIZE)
- K_SIZE, 3, square kernel size (≥ 1)

Widths: RW = max(1,$clog2(IMG_H)), CW = max(1,$clog2(IMG_W)), KW = max(1,$clog2(K_SIZE)).

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a layer pass
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle pulse after final beat accepted
- idx_valid  out  1  index beat available
- idx_ready  in  1  datapath accepts beat
- out_row  out  RW  window origin row, 0..IMG_H-K_SIZE
- out_col  out  CW  window origin column, 0..IMG_W-K_SIZE
- k_row  out  KW  kernel tap row, 0..K_SIZE-1
- k_col  out  KW  kernel tap column, 0..K_SIZE-1
- win_last  out  1  beat is the last tap of its window (k_row=k_col=K_SIZE-1)
- pass_last  out  1  beat is the final beat of the pass

## Operation
- States: IDLE, RUN, DONE. All outputs 0 in reset; state IDLE.
- IDLE: start=1 → RUN. All index registers are cleared to 0. start is ignored in RUN and DONE.
- RUN: idx_valid=1. A beat transfers when idx_valid && idx_ready. Indices advance only on transfer and hold otherwise.
- Loop order, innermost first: k_col, k_row, out_col, out_row. Each field wraps to 0 at its maximum and carries into the next.
- Transfer with pass_last=1 → DONE. Indices return to 0.
- DONE: done=1, busy=1, idx_valid=0 for exactly one cycle → IDLE.
- win_last and pass_last are combinational decodes of the current index registers. They are qualified by idx_valid.
- Beats per pass = (IMG_H-K_SIZE+1)·(IMG_W-K_SIZE+1)·K_SIZE².
- K_SIZE=1: k_row and k_col are held at 0, and win_last=1 on every beat.
- rst_n low at any time, mid-pass included: immediate return to IDLE with all outputs 0. No done pulse is issued.
- idx_ready is a don't-care while idx_valid=0.

## Timing
- start sampled at edge t in IDLE → busy=1 and idx_valid=1 with all indices 0 from t+1.
- Throughput: one beat per cycle while idx_ready=1. No bubbles occur at window or row boundaries.
- Last transfer at edge n → done=1, idx_valid=0 in cycle n+1 → busy=0 at n+2. Earliest next accepted start is at edge n+2.
- Index outputs are registered. idx_valid depends only on state.

## Configuration
- SEQ_STALL_CNT_EN defined: adds output stall_cnt [15:0], reset 0.
  - Cleared on accepted start.
  - Increments each RUN cycle with idx_valid && !idx_ready.
  - Saturates at 16'hFFFF and holds its value after the pass.
- Not defined: port and logic are absent. Behaviour is otherwise identical.

## Test plan
- Defaults (5,5,3), idx_ready=1, start pulse:
  - exactly 81 beats on consecutive cycles;
  - first beat (0,0,0,0), last beat (2,2,2,2) with pass_last=1;
  - win_last on beats 9,18,…,81;
  - done one cycle after beat 81, busy low the cycle after.
- Defaults, idx_ready toggling randomly 50%:
  - beat sequence identical to the no-stall run;
  - indices held stable while idx_ready=0;
  - with SEQ_STALL_CNT_EN, stall_cnt equals the number of stalled cycles.
- start held high throughout a pass and in the DONE cycle:
  - only one pass runs;
  - a new pass starts only from IDLE, at the edge after busy falls.
- rst_n asserted after beat 40:
  - all outputs 0 immediately, no done pulse;
  - next start restarts at indices (0,0,0,0).
- IMG_W=4, IMG_H=3, K_SIZE=1:
  - 12 beats, win_last on every beat;
  - out_col wraps 3→0 with out_row incrementing;
  - final beat (2,3,0,0) with pass_last=1.
- K_SIZE=IMG_W=IMG_H=3:
  - single window, 9 beats;
  - out_row and out_col stay 0, pass_last coincides with win_last.
